mosbius_cfg_readback: RTL and testbench

- Serial readback transmitter for the MOSbius switch-matrix configuration chain; the transmit side of the host-driven SPI-style configuration link.
- Snapshots the live configuration vector when chip-select is asserted and shifts it out MSB-first on the host's serial clock.
- Lets the host verify a loaded switch pattern without disturbing the analog matrix.
- Sits in the digital top: sck/cs_n arrive from ui_in, sdo leaves on uio_out with uio_oe driven from sdo_oe.

---
 rtl/mosbius_pkg.sv | 17 +
 rtl/mosbius_sync_edge.sv | 35 +++
 rtl/mosbius_cfg_readback.sv | 166 ++++++++++++++++
 tb/tb_mosbius_cfg_readback.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mosbius_pkg.sv
// mosbius_pkg: shared types, CRC constants and CRC step function for the MOSbius readback path
package mosbius_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } rb_state_t;

    localparam int             RB_CRC_W    = 8;
    localparam logic [RB_CRC_W-1:0] RB_CRC_POLY = 8'h07;

    function automatic logic [RB_CRC_W-1:0] crc8_step(input logic [RB_CRC_W-1:0] crc, input logic b);
        return {crc[RB_CRC_W-2:0], 1'b0} ^ (((crc[RB_CRC_W-1] ^ b) == 1'b1) ? RB_CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/mosbius_sync_edge.sv
// mosbius_sync_edge: synchronizes an async pin and produces single-cycle rise/fall strobes
//   clk, rst : system clock, sync active-high reset
//   d_i      : asynchronous input pin
//   q_o      : synchronized level
//   rise_o   : one-cycle pulse on a synchronized 0->1 transition
//   fall_o   : one-cycle pulse on a synchronized 1->0 transition
module mosbius_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~hist_q;
    assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/mosbius_cfg_readback.sv
// mosbius_cfg_readback: serial MSB-first readback of the switch-matrix configuration chain
//   clk, rst : system clock, sync active-high reset
//   cfg_q    : live configuration vector, snapshotted on chip-select fall
//   sck_i    : host serial clock (async, SPI mode 0), data advances on its falling edge
//   cs_n_i   : host chip-select, active-low, async
//   sdo_o    : serial data out; sdo_oe drives the pad enable
//   busy_o   : transfer active; done_o pulses when a complete frame ends
// Optional MOSBIUS_RB_CRC_EN appends a CRC-8 (poly 0x07) after the data bits.
module mosbius_cfg_readback
    import mosbius_pkg::*;
#(
    parameter int CFG_BITS    = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CFG_BITS-1:0] cfg_q,
    input  logic                sck_i,
    input  logic                cs_n_i,
    output logic                sdo_o,
    output logic                sdo_oe,
    output logic                busy_o,
    output logic                done_o
);

    localparam int                CNT_W    = $clog2(CFG_BITS + 8) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CFG_BITS + 8);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;

    mosbius_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sck_i),
        .q_o    (sck_lvl),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    mosbius_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cs_n_i),
        .q_o    (cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // Host samples on sck rise, so only the fall strobe drives the shifter.
    logic unused_sync;
    assign unused_sync = sck_lvl ^ sck_rise ^ cs_lvl;

    rb_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [CFG_BITS-1:0]   shadow_q, shadow_d, shift_nxt;
    logic                  sdo_q, sdo_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tail_ok;
`ifdef MOSBIUS_RB_CRC_EN
    logic [RB_CRC_W-1:0]   crc_q, crc_d, crc_nxt;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        sdo_d     = sdo_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_inc   = (cnt_q == CNT_TERM) ? cnt_q : cnt_q + CNT_W'(1);
        shift_nxt = {shadow_q[CFG_BITS-2:0], 1'b0};
`ifdef MOSBIUS_RB_CRC_EN
        crc_d     = crc_q;
        crc_nxt   = crc8_step(crc_q, shadow_q[CFG_BITS-1]);
        tail_ok   = (cnt_q == CNT_TERM);
`else
        tail_ok   = 1'b1;
`endif
        // cs_rise has priority over any coincident sck_fall.
        if (cs_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            sdo_d   = 1'b0;
            done_d  = (state_q == TAIL) && tail_ok;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d  = SHIFT;
                        shadow_d = cfg_q;
                        sdo_d    = cfg_q[CFG_BITS-1];
                        oe_d     = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = CNT_W'(1);
`ifdef MOSBIUS_RB_CRC_EN
                        crc_d    = '0;
`endif
                    end
                end
                SHIFT: begin
                    if (sck_fall) begin
                        cnt_d    = cnt_inc;
                        shadow_d = shift_nxt;
`ifdef MOSBIUS_RB_CRC_EN
                        crc_d    = crc_nxt;
`endif
                        if (cnt_q == CNT_LAST) begin
                            state_d = TAIL;
`ifdef MOSBIUS_RB_CRC_EN
                            // Reuse the emptied shadow to stream the CRC out MSB-first.
                            shadow_d = CFG_BITS'(crc_nxt) << (CFG_BITS - RB_CRC_W);
`endif
                        end
                        sdo_d = shadow_d[CFG_BITS-1];
                    end
                end
                TAIL: begin
                    if (sck_fall) begin
                        cnt_d    = cnt_inc;
                        shadow_d = shift_nxt;
                        sdo_d    = shift_nxt[CFG_BITS-1];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            sdo_q    <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MOSBIUS_RB_CRC_EN
            crc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sdo_q    <= sdo_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MOSBIUS_RB_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign sdo_o  = sdo_q;
    assign sdo_oe = oe_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_mosbius_cfg_readback.sv
// tb_mosbius_cfg_readback: table-driven checks of frames, aborts, snapshot, overrun, CRC tail and reset
module tb_mosbius_cfg_readback;

`ifdef MOSBIUS_RB_CRC_EN
    localparam int FULL = 72;
`else
    localparam int FULL = 64;
`endif

    typedef struct {
        logic [63:0] cfg;
        int          pulses;
        bit          zap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic [63:0] cfg = '0;
    logic        sdo_o, sdo_oe, busy_o, done_o;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;

    mosbius_cfg_readback #(.CFG_BITS(64), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .cfg_q  (cfg),
        .sck_i  (sck),
        .cs_n_i (cs_n),
        .sdo_o  (sdo_o),
        .sdo_oe (sdo_oe),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [63:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 63; i >= 0; i--)
            c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction

    // done must coincide with busy falling.
    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            chk("done_with_busy_fall", {busy_prev, busy_o}, 2'b10);
        end
        busy_prev = busy_o;
    end

    task automatic pulses(input int n, inout logic [71:0] rx);
        for (int i = 0; i < n; i++) begin
            repeat (8) @(negedge clk);
            sck = 1'b1;
            rx = {rx[70:0], sdo_o};
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [71:0] rx, exp_rx;
        logic [7:0]  tail;
        int          d0;
        rx = '0;
        cfg = v.cfg;
        d0 = done_cnt;
`ifdef MOSBIUS_RB_CRC_EN
        tail = crc_ref(v.cfg);
`else
        tail = 8'h00;
`endif
        exp_rx = {v.cfg, tail} >> (72 - v.pulses);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_oe_active", idx), sdo_oe, 1'b1);
        chk($sformatf("v%0d_busy_active", idx), busy_o, 1'b1);
        if (v.zap) cfg = '0;
        pulses(v.pulses, rx);
        repeat (8) @(negedge clk);
        chk($sformatf("v%0d_readback", idx), rx, exp_rx);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_oe_hold", idx), sdo_oe, 1'b1);
        @(negedge clk);
        chk($sformatf("v%0d_idle_outs", idx), {sdo_oe, busy_o, sdo_o}, 3'b000);
        repeat (6) @(negedge clk);
        chk($sformatf("v%0d_done_count", idx), done_cnt - d0, (v.pulses >= FULL) ? 1 : 0);
    endtask

    vec_t vecs[7];

    initial begin
        logic [71:0] rx;
        int d0;
        vecs[0] = '{64'hA5A5_0000_FFFF_1234, 64, 1'b0};
        vecs[1] = '{64'hA5A5_0000_FFFF_1234, 20, 1'b0};
        vecs[2] = '{64'hA5A5_0000_FFFF_1234, 64, 1'b0};
        vecs[3] = '{64'hDEAD_BEEF_0123_4567, 64, 1'b1};
        vecs[4] = '{64'h0000_0000_0000_0001, 72, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 72, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outs", {sdo_o, sdo_oe, busy_o, done_o}, 4'b0000);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_reset_outs", {sdo_o, sdo_oe, busy_o, done_o}, 4'b0000);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset in the middle of the tail: no done, outputs back to reset values.
        d0 = done_cnt;
        rx = '0;
        cfg = 64'h1;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        pulses(68, rx);
        repeat (4) @(negedge clk);
        chk("midrst_pre_oe", sdo_oe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {sdo_o, sdo_oe, busy_o, done_o}, 4'b0000);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle_outs", {sdo_o, sdo_oe, busy_o}, 3'b000);

        run_vec(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
